// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    localparam logic IDLE_BIT_DEFAULT = 1'b1;

    // Serial frame length in bits: data bits plus the optional parity bit.
    function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
        return parity_en ? data_w + 1 : data_w;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: DATA_W-bit words leave on x MSB first over valid/ready.
// Define SER_PARITY_EN to append an even-parity bit after the LSB of each frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter logic        IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              busy,
    output logic              frame_done
);

`ifdef SER_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif
    localparam int unsigned     FrameLen = frame_len(DATA_W, ParityEn);
    localparam int unsigned     CntW     = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCnt  = CntW'(FrameLen - 1);
`ifdef SER_PARITY_EN
    localparam logic [CntW-1:0] LsbCnt   = CntW'(DATA_W - 1);
`endif

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              x_q, x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SER_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic              last_bit;
    logic              accept;

    always_comb begin
        last_bit  = (state_q == ST_SHIFT) && (cnt_q == LastCnt);
        din_ready = !reset && ((state_q == ST_IDLE) || last_bit);
        accept    = din_valid && din_ready;

        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        busy_d   = busy_q;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            // MSB goes straight to x; shift_q keeps the word so x_d can track shift_q[DATA_W-2].
            state_d  = ST_SHIFT;
            shift_d  = din;
            cnt_d    = '0;
            x_d      = din[DATA_W-1];
            busy_d   = 1'b1;
`ifdef SER_PARITY_EN
            parity_d = ^din;
`endif
        end else if (last_bit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            x_d     = IDLE_BIT;
            busy_d  = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            cnt_d   = cnt_q + CntW'(1);
            shift_d = shift_q << 1;
            x_d     = shift_q[DATA_W-2];
`ifdef SER_PARITY_EN
            if (cnt_q == LsbCnt) begin
                x_d = parity_q;
            end
`endif
        end

        done_d = (state_d == ST_SHIFT) && (cnt_d == LastCnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            x_q      <= IDLE_BIT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign x          = x_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: queue-based frame model plus directed literal checks.
module tb_bit_serializer;

    localparam int unsigned DATA_W = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned FL = DATA_W + 1;
`else
    localparam int unsigned FL = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic              x;
    logic              busy;
    logic              frame_done;

    bit_serializer #(
        .DATA_W  (DATA_W),
        .IDLE_BIT(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the bits still to appear on x, head is the bit currently on x.
    bit m_bits[$];
    bit m_busy = 1'b0;

    function automatic void m_clear();
        m_bits.delete();
        m_busy = 1'b0;
    endfunction

    function automatic void m_load(input logic [DATA_W-1:0] w);
        m_bits.delete();
        for (int i = DATA_W - 1; i >= 0; i--) m_bits.push_back(w[i]);
`ifdef SER_PARITY_EN
        m_bits.push_back(^w);
`endif
        m_busy = 1'b1;
    endfunction

    function automatic bit m_ready();
        return !reset && (!m_busy || m_bits.size() == 1);
    endfunction

    always @(posedge reset) m_clear();

    always @(posedge clk) begin
        if (reset) begin
            m_clear();
        end else if (din_valid && m_ready()) begin
            m_load(din);
        end else if (m_busy) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) m_busy = 1'b0;
        end
    end

    // Per-cycle compare against the model, with optional logging for literal checks.
    bit   log_en = 1'b0;
    logic xl[$];
    logic dl[$];
    logic rl[$];
    logic bl[$];

    always @(negedge clk) begin
        check("model_x", {31'd0, x}, {31'd0, (m_busy ? m_bits[0] : 1'b1)});
        check("model_busy", {31'd0, busy}, {31'd0, m_busy});
        check("model_done", {31'd0, frame_done}, {31'd0, (m_busy && m_bits.size() == 1)});
        check("model_ready", {31'd0, din_ready}, {31'd0, m_ready()});
        if (log_en) begin
            xl.push_back(x);
            dl.push_back(frame_done);
            rl.push_back(din_ready);
            bl.push_back(busy);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xl.delete();
        dl.delete();
        rl.delete();
        bl.delete();
    endtask

    function automatic logic [31:0] pack_x(input int first, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], xl[first + i]};
        return v;
    endfunction

    function automatic int count_high(input int first, input int n, input bit use_done);
        int c = 0;
        for (int i = 0; i < n; i++) c += use_done ? int'(dl[first + i]) : int'(rl[first + i]);
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check("rst_x", {31'd0, x}, 32'd1);
        check("rst_ready", {31'd0, din_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, din_ready}, 32'd1);

        // Single word A5.
        clear_logs();
        log_en = 1'b1;
        din = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (FL) tick();
        log_en = 1'b0;
        check("a5_bits", pack_x(0, 8), 32'h0000_00A5);
        check("a5_done_cnt", count_high(0, FL + 1, 1'b1), 32'd1);
        check("a5_done_last", {31'd0, dl[FL-1]}, 32'd1);
        check("a5_busy_first", {31'd0, bl[0]}, 32'd1);
        check("a5_busy_after", {31'd0, bl[FL]}, 32'd0);
        check("a5_idle_x", {31'd0, xl[FL]}, 32'd1);
`ifdef SER_PARITY_EN
        check("a5_parity", {31'd0, xl[8]}, 32'd0);
`endif

        // Back-to-back 00 then FF with valid held high.
        clear_logs();
        log_en = 1'b1;
        din = 8'h00;
        din_valid = 1'b1;
        tick();
        din = 8'hFF;
        repeat (FL) tick();
        din_valid = 1'b0;
        repeat (FL) tick();
        log_en = 1'b0;
`ifdef SER_PARITY_EN
        check("b2b_bits", pack_x(0, 2 * FL), 32'b000000000_111111110);
`else
        check("b2b_bits", pack_x(0, 2 * FL), 32'h0000_00FF);
`endif
        check("b2b_ready_cnt", count_high(0, 2 * FL, 1'b0), 32'd2);
        check("b2b_ready_w1", {31'd0, rl[FL-1]}, 32'd1);
        check("b2b_ready_w2", {31'd0, rl[2*FL-1]}, 32'd1);
        check("b2b_done_cnt", count_high(0, 2 * FL, 1'b1), 32'd2);
        check("b2b_idle_x", {31'd0, xl[2*FL]}, 32'd1);

        // Backpressure: din/din_valid wiggle while din_ready is low.
        clear_logs();
        log_en = 1'b1;
        din = 8'h3C;
        din_valid = 1'b1;
        tick();
        for (int k = 1; k < int'(FL); k++) begin
            din_valid = (k % 2 == 1);
            din = 8'hFF;
            tick();
        end
        din_valid = 1'b0;
        tick();
        log_en = 1'b0;
        check("bp_bits", pack_x(0, 8), 32'h0000_003C);
        check("bp_done_cnt", count_high(0, FL + 1, 1'b1), 32'd1);

        // Reset asserted while the 4th bit of 0F is on x.
        clear_logs();
        log_en = 1'b1;
        din = 8'h0F;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        check("mid_x_before", {31'd0, x}, 32'd0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_x", {31'd0, x}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, frame_done}, 32'd0);
        check("mid_rst_ready", {31'd0, din_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_release_ready", {31'd0, din_ready}, 32'd1);
        din = 8'hC3;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (FL) tick();
        log_en = 1'b0;
        check("mid_next_bits", pack_x(5, 8), 32'h0000_00C3);
        check("mid_done_cnt", count_high(0, 6 + FL, 1'b1), 32'd1);
        check("mid_done_pos", {31'd0, dl[FL+4]}, 32'd1);

`ifdef SER_PARITY_EN
        clear_logs();
        log_en = 1'b1;
        din = 8'h07;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (FL) tick();
        log_en = 1'b0;
        check("par07_bits", pack_x(0, 9), 32'b000001111);
        check("par07_done", {31'd0, dl[8]}, 32'd1);

        clear_logs();
        log_en = 1'b1;
        din = 8'h03;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (FL) tick();
        log_en = 1'b0;
        check("par03_bit", {31'd0, xl[8]}, 32'd0);
`endif

        // Randomized traffic with occasional resets; the per-cycle compare does the checking.
        for (int n = 0; n < 3000; n++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din = DATA_W'($urandom);
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        din_valid = 1'b0;
        repeat (FL + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
